// File: rtl/pix_i2c_pkg.sv
// pix_i2c_pkg: shared state encoding and bus constants for the pixel-sensor I2C responder.
// Contents: i2c_state_t (responder FSM states), I2C_ACK/I2C_NACK bus levels,
// RW_BIT (position of the read/write flag in the address byte), drives_ack().
package pix_i2c_pkg;
   typedef enum logic [3:0] {
      ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG_HI, ST_REG_HI_ACK, ST_REG_LO,
      ST_REG_LO_ACK, ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
   } i2c_state_t;
   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;
   localparam int   RW_BIT   = 0;
   function automatic logic drives_ack(input i2c_state_t s);
      return s inside {ST_ADDR_ACK, ST_REG_HI_ACK, ST_REG_LO_ACK, ST_WR_ACK};
   endfunction
endpackage

// File: rtl/pix_i2c_bus_sync.sv
// pix_i2c_bus_sync: synchronizes SCL/SDA into clk and flags line events.
// Ports: clk, rst_n (async active-low); scl_pin/sda_pin raw bus lines;
// sda synchronized SDA level; scl_rise/scl_fall one-cycle SCL edges;
// start/stop one-cycle START(or Sr)/STOP conditions.
module pix_i2c_bus_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_pin,
   input  logic sda_pin,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);
   logic [1:0] scl_s, sda_s;
   logic       scl_d, sda_d, scl, scl_hold;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_s <= 2'b11;
         sda_s <= 2'b11;
         scl_d <= 1'b1;
         sda_d <= 1'b1;
      end else begin
         scl_s <= {scl_s[0], scl_pin};
         sda_s <= {sda_s[0], sda_pin};
         scl_d <= scl_s[1];
         sda_d <= sda_s[1];
      end
   end
   assign scl      = scl_s[1];
   assign sda      = sda_s[1];
   assign scl_rise = scl & ~scl_d;
   assign scl_fall = ~scl & scl_d;
   // SCL must be high in both samples, so an SDA edge coinciding with an SCL edge is not a START/STOP
   assign scl_hold = scl & scl_d;
   assign start    = scl_hold & sda_d & ~sda;
   assign stop     = scl_hold & ~sda_d & sda;
endmodule

// File: rtl/pix_i2c_slave.sv
// pix_i2c_slave: I2C responder for the pixel-sensor register protocol (7-bit addr, 16-bit reg addr, 8/16-bit data).
// Ports: clk, rst_n (async active-low); i2c_clk/i2c_data_in bus lines; i2c_data_oe pulls SDA low;
// reg_addr/reg_wdata/reg_wlen/reg_write write strobe interface; reg_read/reg_rdata read interface
// (reg_rdata valid the cycle after reg_read); busy high from own-address ACK until STOP.
module pix_i2c_slave
   import pix_i2c_pkg::*;
#(
   parameter logic [6:0] SlaveAddr = 7'h42,
   parameter int         ClkFreq   = 48_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i2c_clk,
   input  logic        i2c_data_in,
   output logic        i2c_data_oe,
   output logic [15:0] reg_addr,
   output logic [15:0] reg_wdata,
   output logic        reg_wlen,
   output logic        reg_write,
   output logic        reg_read,
   input  logic [15:0] reg_rdata,
   output logic        busy
);
   if (ClkFreq < 20 * 400_000) begin : g_clk_chk
      $error("ClkFreq too low to oversample a 400 kHz SCL");
   end
   i2c_state_t  state, state_n;
   logic        sda, scl_rise, scl_fall, start, stop;
   logic [3:0]  cnt;
   logic [7:0]  sh, wbuf, byte_in;
   logic [1:0]  wcnt;
   logic [15:0] tx;
   logic        rd_dly, ack_ok, rx_state, byte_done;
   pix_i2c_bus_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .scl_pin  (i2c_clk),
      .sda_pin  (i2c_data_in),
      .sda      (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );
   assign byte_in   = {sh[6:0], sda};
   assign rx_state  = state inside {ST_ADDR, ST_REG_HI, ST_REG_LO, ST_WR_DATA};
   assign byte_done = cnt == 4'd8;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end
   // Received bytes end on the SCL fall after their 8th bit; ACK slots end on the next fall.
   always_comb begin
      state_n = state;
      if (start) state_n = ST_ADDR;
      else if (stop) state_n = ST_IDLE;
      else if (scl_fall) begin
         case (state)
            ST_ADDR:       if (byte_done) state_n = (sh[7:1] == SlaveAddr) ? ST_ADDR_ACK : ST_IGNORE;
            ST_REG_HI:     if (byte_done) state_n = ST_REG_HI_ACK;
            ST_REG_LO:     if (byte_done) state_n = ST_REG_LO_ACK;
            ST_WR_DATA:    if (byte_done) state_n = ST_WR_ACK;
            ST_ADDR_ACK:   state_n = sh[RW_BIT] ? ST_RD_DATA : ST_REG_HI;
            ST_REG_HI_ACK: state_n = ST_REG_LO;
            ST_REG_LO_ACK: state_n = ST_WR_DATA;
            ST_WR_ACK:     state_n = ST_WR_DATA;
            ST_RD_DATA:    if (cnt == 4'd7) state_n = ST_RD_ACK;
            ST_RD_ACK:     state_n = ack_ok ? ST_RD_DATA : ST_IGNORE;
            default:       state_n = state;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         sh          <= '0;
         wbuf        <= '0;
         wcnt        <= '0;
         tx          <= '1;
         rd_dly      <= 1'b0;
         ack_ok      <= 1'b0;
         i2c_data_oe <= 1'b0;
         reg_addr    <= '0;
         reg_wdata   <= '0;
         reg_wlen    <= 1'b0;
         reg_write   <= 1'b0;
         reg_read    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         reg_write <= 1'b0;
         reg_read  <= 1'b0;
         rd_dly    <= reg_read;
         if (start || state_n != state) cnt <= '0;
         else if ((scl_rise && rx_state) || (scl_fall && state == ST_RD_DATA)) cnt <= cnt + 4'd1;
         if (scl_rise && rx_state) sh <= byte_in;
         if (scl_rise && cnt == 4'd7) begin
            if (state == ST_REG_HI) reg_addr[15:8] <= byte_in;
            if (state == ST_REG_LO) reg_addr[7:0] <= byte_in;
            if (state == ST_WR_DATA && wcnt == 2'd0) begin
               wbuf <= byte_in;
               wcnt <= 2'd1;
            end else if (state == ST_WR_DATA && wcnt == 2'd1) begin
               reg_write <= 1'b1;
               reg_wlen  <= 1'b1;
               reg_wdata <= {wbuf, byte_in};
               wcnt      <= 2'd2;
            end
         end
         // A single pending data byte is committed only by STOP; Sr discards it
         if (stop && wcnt == 2'd1) begin
            reg_write <= 1'b1;
            reg_wlen  <= 1'b0;
            reg_wdata <= {8'h00, wbuf};
         end
         if (start || stop) wcnt <= '0;
         if (scl_rise && state == ST_RD_ACK) ack_ok <= (sda == I2C_ACK);
         // tx is held all-ones until the read data arrives so SDA stays released meanwhile;
         // shifting in ones makes every byte after the second read as 8'hFF
         if (state == ST_ADDR_ACK && state_n == ST_RD_DATA) begin
            reg_read <= 1'b1;
            tx       <= '1;
         end else if (rd_dly) tx <= reg_rdata;
         else if (scl_fall && state == ST_RD_DATA) tx <= {tx[14:0], 1'b1};
         if (stop) busy <= 1'b0;
         else if (state == ST_ADDR && state_n == ST_ADDR_ACK) busy <= 1'b1;
         i2c_data_oe <= (start || stop) ? 1'b0 : (drives_ack(state) || (state == ST_RD_DATA && !tx[15]));
      end
   end
endmodule

// File: tb/tb_pix_i2c_slave.sv
// tb_pix_i2c_slave: directed bench for pix_i2c_slave, a bus master built from tasks plus strobe monitor.
module tb_pix_i2c_slave;
   localparam int Q = 10;
   logic        clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_m = 1'b1;
   logic        oe, reg_write, reg_read, reg_wlen, busy, sda_bus;
   logic [15:0] reg_addr, reg_wdata;
   logic [15:0] reg_rdata = 16'h0000, rd_val = 16'h0000;
   logic [15:0] cap_addr = 16'h0000, cap_wdata = 16'h0000;
   logic        cap_wlen = 1'b0, wr_prev = 1'b0;
   int          wr_cnt = 0, rd_cnt = 0, oe_cnt = 0, wide = 0;
   int          n_vec = 0, n_bad = 0;
   assign sda_bus = sda_m & ~oe;
   always #5 clk = ~clk;
   pix_i2c_slave dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i2c_clk     (scl),
      .i2c_data_in (sda_bus),
      .i2c_data_oe (oe),
      .reg_addr    (reg_addr),
      .reg_wdata   (reg_wdata),
      .reg_wlen    (reg_wlen),
      .reg_write   (reg_write),
      .reg_read    (reg_read),
      .reg_rdata   (reg_rdata),
      .busy        (busy)
   );
   always @(negedge clk) begin
      if (reg_write) begin
         wr_cnt++;
         cap_addr  = reg_addr;
         cap_wdata = reg_wdata;
         cap_wlen  = reg_wlen;
      end
      if (reg_read) begin
         rd_cnt++;
         reg_rdata = rd_val;
      end
      if (reg_write && wr_prev) wide++;
      wr_prev = reg_write;
      if (oe) oe_cnt++;
   end
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic i2c_start();
      sda_m = 1'b1; tick(Q); scl = 1'b1; tick(Q); sda_m = 1'b0; tick(Q); scl = 1'b0; tick(Q);
   endtask
   task automatic i2c_stop();
      sda_m = 1'b0; tick(Q); scl = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
   endtask
   task automatic wbits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; tick(Q); scl = 1'b1; tick(2 * Q); scl = 1'b0; tick(Q);
      end
   endtask
   task automatic wbyte(input logic [7:0] b, output logic ack);
      wbits(b);
      sda_m = 1'b1; tick(Q); scl = 1'b1; tick(Q); ack = sda_bus; tick(Q); scl = 1'b0; tick(Q);
   endtask
   task automatic rbyte(output logic [7:0] b, input logic send_ack);
      sda_m = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         tick(Q); scl = 1'b1; tick(Q); b[i] = sda_bus; tick(Q); scl = 1'b0;
      end
      tick(Q); sda_m = send_ack ? 1'b0 : 1'b1; tick(Q); scl = 1'b1; tick(2 * Q); scl = 1'b0; tick(Q);
      sda_m = 1'b1;
   endtask
   task automatic test_reset();
      rst_n = 1'b0; tick(3);
      n_vec++;
      if (oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe_async: got %b want 0", oe); end
      rst_n = 1'b1; tick(4);
      n_vec++;
      if ({oe, reg_write, reg_read, busy, reg_wlen} !== 5'b00000) begin
         n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {oe, reg_write, reg_read, busy, reg_wlen});
      end
      n_vec++;
      if (reg_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_addr: got %h want 0000", reg_addr); end
      n_vec++;
      if (reg_wdata !== 16'h0000) begin n_bad++; $display("FAIL reset_wdata: got %h want 0000", reg_wdata); end
   endtask
   task automatic test_write_two();
      logic [4:0] a;
      int w0 = wr_cnt, wd0 = wide;
      i2c_start();
      wbyte(8'h84, a[0]); wbyte(8'h12, a[1]); wbyte(8'h34, a[2]); wbyte(8'h56, a[3]); wbyte(8'h78, a[4]);
      n_vec++;
      if (a !== 5'b00000) begin n_bad++; $display("FAIL wr2_acks: got %b want 00000", a); end
      n_vec++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL wr2_busy_mid: got %b want 1", busy); end
      i2c_stop(); tick(6);
      n_vec++;
      if (wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL wr2_count: got %0d want 1", wr_cnt - w0); end
      n_vec++;
      if (cap_addr !== 16'h1234) begin n_bad++; $display("FAIL wr2_addr: got %h want 1234", cap_addr); end
      n_vec++;
      if (cap_wdata !== 16'h5678) begin n_bad++; $display("FAIL wr2_wdata: got %h want 5678", cap_wdata); end
      n_vec++;
      if (cap_wlen !== 1'b1) begin n_bad++; $display("FAIL wr2_wlen: got %b want 1", cap_wlen); end
      n_vec++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL wr2_busy_end: got %b want 0", busy); end
      n_vec++;
      if (wide - wd0 !== 0) begin n_bad++; $display("FAIL wr2_pulse_width: got %0d wide pulses want 0", wide - wd0); end
   endtask
   task automatic test_write_one();
      logic [3:0] a;
      int w0 = wr_cnt;
      i2c_start();
      wbyte(8'h84, a[0]); wbyte(8'h00, a[1]); wbyte(8'hAA, a[2]); wbyte(8'h5C, a[3]);
      tick(6);
      n_vec++;
      if (wr_cnt - w0 !== 0) begin n_bad++; $display("FAIL wr1_early: got %0d writes want 0", wr_cnt - w0); end
      i2c_stop(); tick(6);
      n_vec++;
      if (a !== 4'b0000) begin n_bad++; $display("FAIL wr1_acks: got %b want 0000", a); end
      n_vec++;
      if (wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL wr1_count: got %0d want 1", wr_cnt - w0); end
      n_vec++;
      if ({cap_addr, cap_wdata, cap_wlen} !== {16'h00AA, 16'h005C, 1'b0}) begin
         n_bad++; $display("FAIL wr1_data: got addr %h wdata %h wlen %b want 00aa 005c 0", cap_addr, cap_wdata, cap_wlen);
      end
   endtask
   task automatic test_read();
      logic [3:0] a;
      logic [7:0] b0, b1;
      int w0 = wr_cnt, r0 = rd_cnt;
      rd_val = 16'hBEEF;
      i2c_start();
      wbyte(8'h84, a[0]); wbyte(8'hAB, a[1]); wbyte(8'hCD, a[2]);
      i2c_start();
      wbyte(8'h85, a[3]);
      rbyte(b0, 1'b1); rbyte(b1, 1'b0);
      n_vec++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL rd_busy_mid: got %b want 1", busy); end
      i2c_stop(); tick(6);
      n_vec++;
      if (a !== 4'b0000) begin n_bad++; $display("FAIL rd_acks: got %b want 0000", a); end
      n_vec++;
      if ({b0, b1} !== 16'hBEEF) begin n_bad++; $display("FAIL rd_data: got %h want beef", {b0, b1}); end
      n_vec++;
      if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 0) begin
         n_bad++; $display("FAIL rd_strobes: got %0d reads %0d writes want 1 0", rd_cnt - r0, wr_cnt - w0);
      end
      n_vec++;
      if (reg_addr !== 16'hABCD) begin n_bad++; $display("FAIL rd_addr: got %h want abcd", reg_addr); end
      n_vec++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy_end: got %b want 0", busy); end
   endtask
   task automatic test_bad_addr();
      logic a, x;
      int w0 = wr_cnt, r0 = rd_cnt, o0 = oe_cnt;
      i2c_start();
      wbyte(8'h86, a); wbyte(8'h12, x);
      i2c_stop(); tick(6);
      n_vec++;
      if (a !== 1'b1) begin n_bad++; $display("FAIL bad_nack: got %b want 1", a); end
      n_vec++;
      if (oe_cnt - o0 !== 0) begin n_bad++; $display("FAIL bad_oe: got %0d driven cycles want 0", oe_cnt - o0); end
      n_vec++;
      if (wr_cnt - w0 + rd_cnt - r0 !== 0) begin n_bad++; $display("FAIL bad_strobes: got %0d want 0", wr_cnt - w0 + rd_cnt - r0); end
      n_vec++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL bad_busy: got %b want 0", busy); end
   endtask
   task automatic test_reset_mid_ack();
      logic [4:0] a;
      int w0;
      i2c_start();
      wbits(8'h84);
      sda_m = 1'b1; tick(Q); scl = 1'b1; tick(Q);
      n_vec++;
      if (oe !== 1'b1) begin n_bad++; $display("FAIL rstmid_ack_drive: got %b want 1", oe); end
      rst_n = 1'b0; #1;
      n_vec++;
      if (oe !== 1'b0) begin n_bad++; $display("FAIL rstmid_release: got %b want 0", oe); end
      tick(2); scl = 1'b0; tick(Q); scl = 1'b1; tick(Q);
      rst_n = 1'b1; tick(4);
      w0 = wr_cnt;
      i2c_start();
      wbyte(8'h84, a[0]); wbyte(8'h01, a[1]); wbyte(8'h02, a[2]); wbyte(8'hA5, a[3]); wbyte(8'hB6, a[4]);
      i2c_stop(); tick(6);
      n_vec++;
      if (a !== 5'b00000) begin n_bad++; $display("FAIL rstmid_acks: got %b want 00000", a); end
      n_vec++;
      if (wr_cnt - w0 !== 1 || cap_addr !== 16'h0102 || cap_wdata !== 16'hA5B6) begin
         n_bad++; $display("FAIL rstmid_write: got %0d writes addr %h wdata %h want 1 0102 a5b6", wr_cnt - w0, cap_addr, cap_wdata);
      end
   endtask
   task automatic test_sr_mid_write();
      logic [4:0] a;
      logic [7:0] b0, b1;
      int w0 = wr_cnt, r0 = rd_cnt;
      rd_val = 16'h3C3D;
      i2c_start();
      wbyte(8'h84, a[0]); wbyte(8'h00, a[1]); wbyte(8'h77, a[2]); wbyte(8'h11, a[3]);
      i2c_start();
      wbyte(8'h85, a[4]);
      rbyte(b0, 1'b1); rbyte(b1, 1'b0);
      i2c_stop(); tick(6);
      n_vec++;
      if (a !== 5'b00000) begin n_bad++; $display("FAIL sr_acks: got %b want 00000", a); end
      n_vec++;
      if (wr_cnt - w0 !== 0) begin n_bad++; $display("FAIL sr_no_write: got %0d writes want 0", wr_cnt - w0); end
      n_vec++;
      if (rd_cnt - r0 !== 1) begin n_bad++; $display("FAIL sr_reads: got %0d want 1", rd_cnt - r0); end
      n_vec++;
      if ({b0, b1} !== 16'h3C3D || reg_addr !== 16'h0077) begin
         n_bad++; $display("FAIL sr_read: got data %h addr %h want 3c3d 0077", {b0, b1}, reg_addr);
      end
   endtask
   initial begin
      test_reset();
      test_write_two();
      test_write_one();
      test_read();
      test_bad_addr();
      test_reset_mid_ack();
      test_sr_mid_write();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/pix_i2c_slave.md
# pix_i2c_slave

Synthesizable I2C responder that terminates the pixel-sensor register protocol driven by PixI2CMaster: 7-bit slave address, 16-bit big-endian register address, 8- or 16-bit data. It oversamples SCL/SDA in the system clock domain, decodes START/repeated-START/STOP, ACKs its own address and exposes a simple register read/write strobe interface. It replaces the behavioural slave model in bench tops and is the basis for emulating the image sensor's control port on hardware.

## Interface
- SlaveAddr, 7'h42, 7-bit address this block ACKs; all other addresses are ignored (SDA released)
- ClkFreq, 48_000_000, system clock frequency; must be ≥ 20× SCL frequency (400 kHz max)
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- i2c_clk  in  1  SCL from bus (external pull-up; block never drives SCL, no clock stretching)
- i2c_data_in  in  1  SDA as seen on the bus
- i2c_data_oe  out  1  1 = pull SDA low; 0 = release (top wraps with SB_IO open-drain)
- reg_addr  out  16  register address of current access
- reg_wdata  out  16  write data; 8-bit writes in [7:0], [15:8] = 0
- reg_wlen  out  1  0 = 1-byte write, 1 = 2-byte write; valid with reg_write
- reg_write  out  1  one-cycle pulse: commit reg_wdata to reg_addr
- reg_read  out  1  one-cycle pulse: request read of reg_addr
- reg_rdata  in  16  read data, must be valid on cycle after reg_read
- busy  out  1  1 between own-address ACK and STOP

## Operation
- SCL/SDA each pass a 2-flop synchronizer (reset value 1), then a delay flop for edge detection.
- START/Sr: SDA falls while SCL high → state Addr, bit counter = 0, from any state. STOP: SDA rises while SCL high → Idle, release SDA; pending 1-byte write commits.
- Bits sampled on SCL rising edge, MSB first. SDA changes only on detected SCL falling edge.
- States: Idle, Addr, AddrAck, RegHi, RegHiAck, RegLo, RegLoAck, WrData, WrAck, RdData, RdAck, Ignore.
- Addr: 8 bits. addr[7:1] ≠ SlaveAddr → Ignore (until START/STOP). Match → AddrAck (drive low one SCL period). R/W=0 → RegHi; R/W=1 → RdData.
- RegHi/RegLo: load reg_addr[15:8]/[7:0], ACK each. After RegLoAck → WrData.
- WrData: byte 0 → wdata hi-holding reg, ACK; byte 1 → ACK, then reg_write with reg_wlen=1, reg_wdata={b0,b1}. Further bytes: ACK, ignored. STOP after exactly one data byte → reg_write with reg_wlen=0, reg_wdata={8'h00,b0}. STOP/Sr with zero data bytes → no write (address-only setup for read).
- RdData: on entry pulse reg_read, latch reg_rdata next cycle into tx shift reg (before first SCL falling edge of data). Send [15:8] then [7:0]. RdAck: release SDA, sample master ACK; ACK after byte 0 → send byte 1; ACK after byte 1 → send 8'hFF; NACK → Ignore.
- reg_addr is not auto-incremented.

## Timing
- Reset: i2c_data_oe=0, reg_write=0, reg_read=0, busy=0, reg_addr=0, reg_wdata=0, reg_wlen=0, state Idle. Reset mid-transfer releases SDA immediately (async).
- Bus-event latency: 3 clk from pin to state update; SDA drive/release changes 4 clk after pin SCL falling edge (≤ 84 ns @ 48 MHz, within tHD;DAT).
- reg_write / reg_read: exactly one clk wide; reg_write follows the 2nd data-byte sampling edge by 1 clk, or STOP detection by 1 clk.
- Simultaneous SCL and SDA edge in same synchronized cycle: treat as SCL edge only (no START/STOP).
- START during own ACK drive: release SDA same cycle START is detected.

## Structure
- Shared package pix_i2c_pkg: state enum, ACK=0/NACK=1 constants, R/W bit position; shared with PixI2CMaster bench checks.
- One sub-module: pix_i2c_bus_sync (synchronizer + rise/fall/start/stop detect for both lines).

## Test plan
- Write 0x42, reg 0x1234 ← 0x5678 (2 bytes) → all ACKs, one reg_write, reg_addr=0x1234, reg_wdata=0x5678, reg_wlen=1, master status_err=0.
- Write reg 0x00AA ← 0x5C (1 byte) then STOP → reg_write at STOP, reg_wdata=0x005C, reg_wlen=0.
- Read reg 0xABCD (addr write, Sr, read 2 bytes), reg_rdata=0xBEEF → one reg_read, master status_readData=0xBEEF, NACK on last byte, busy drops at STOP.
- Address 0x43 → NACK, i2c_data_oe never asserted, no strobes, master status_err=1.
- rst_n low while driving ACK → i2c_data_oe=0 immediately; next transaction completes normally.
- Sr mid-write after 1 data byte → no reg_write; following read succeeds at same reg_addr.
